// File: rtl/kronos_types.sv
// Shared types for the kronos memory responder: per-port FSM states and wait-counter helpers.
package kronos_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } mem_state_e;

  localparam int CNT_W = 4;

  // Wait-cycle parameters above the counter range saturate rather than wrap.
  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    if (cycles > (1 << CNT_W) - 1) return '1;
    if (cycles < 0) return '0;
    return CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/kronos_dpram.sv
// Word-organised storage: one synchronous read port, one synchronous byte-masked read/write port.
module kronos_dpram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          a_re,
  input  logic [AW-1:0] a_addr,
  output logic [31:0]   a_q,
  input  logic          b_re,
  input  logic          b_we,
  input  logic [3:0]    b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_q
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (a_re) a_q <= mem[a_addr];
  end

  // Reads on port B return the pre-write contents when both happen on one edge.
  always_ff @(posedge clk) begin
    if (b_re) b_q <= mem[b_addr];
    if (b_we) begin
      for (int i = 0; i < 4; i++) begin
        if (b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/kronos_mem_responder.sv
// Two-port memory responder with independent instruction/data FSMs and configurable wait states.
// Define KRONOS_MEM_BOUNDS_EN to flag and suppress accesses beyond the memory instead of wrapping.
module kronos_mem_responder
  import kronos_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IWAIT       = 0,
  parameter int DWAIT       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_gnt,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  output logic [31:0] data_rd_data,
  output logic        data_gnt,
  output logic        bus_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] IWAIT_C = wait_load(IWAIT);
  localparam logic [CNT_W-1:0] DWAIT_C = wait_load(DWAIT);

  logic i_req_oob;
  logic d_req_oob;
  logic unused_addr_bits;

`ifdef KRONOS_MEM_BOUNDS_EN
  assign i_req_oob = (instr_addr >> (AW + 2)) != 32'd0;
  assign d_req_oob = (data_addr >> (AW + 2)) != 32'd0;
`else
  assign i_req_oob = 1'b0;
  assign d_req_oob = 1'b0;
`endif

  assign unused_addr_bits = ^{instr_addr[1:0], instr_addr[31:AW+2],
                              data_addr[1:0], data_addr[31:AW+2]};

  // ---------------- instruction port ----------------
  mem_state_e       i_state_reg, i_state_next;
  logic [CNT_W-1:0] i_cnt_reg, i_cnt_next;
  logic [AW-1:0]    i_idx_reg, i_idx_next;
  logic             i_oob_reg, i_oob_next;
  logic [31:0]      i_hold_reg;
  logic [31:0]      i_ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state_reg <= IDLE;
      i_cnt_reg   <= '0;
      i_idx_reg   <= '0;
      i_oob_reg   <= 1'b0;
    end else begin
      i_state_reg <= i_state_next;
      i_cnt_reg   <= i_cnt_next;
      i_idx_reg   <= i_idx_next;
      i_oob_reg   <= i_oob_next;
    end
  end

  always_comb begin
    i_state_next = i_state_reg;
    i_cnt_next   = i_cnt_reg;
    i_idx_next   = i_idx_reg;
    i_oob_next   = i_oob_reg;
    case (i_state_reg)
      IDLE: begin
        if (instr_req) begin
          i_idx_next   = instr_addr[AW+1:2];
          i_oob_next   = i_req_oob;
          i_cnt_next   = IWAIT_C;
          i_state_next = (IWAIT_C == '0) ? GRANT : WAIT;
        end
      end
      WAIT: begin
        i_cnt_next = i_cnt_reg - CNT_W'(1);
        if (i_cnt_reg <= CNT_W'(1)) i_state_next = GRANT;
      end
      GRANT: begin
        i_cnt_next   = '0;
        i_state_next = IDLE;
      end
      default: i_state_next = IDLE;
    endcase
  end

  assign instr_gnt  = (i_state_reg == GRANT);
  assign instr_data = instr_gnt ? (i_oob_reg ? 32'd0 : i_ram_q) : i_hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) i_hold_reg <= '0;
    else if (instr_gnt) i_hold_reg <= instr_data;
  end

  // ---------------- data port ----------------
  mem_state_e       d_state_reg, d_state_next;
  logic [CNT_W-1:0] d_cnt_reg, d_cnt_next;
  logic [AW-1:0]    d_idx_reg, d_idx_next;
  logic             d_oob_reg, d_oob_next;
  logic             d_wr_reg, d_wr_next;
  logic [31:0]      d_wdata_reg, d_wdata_next;
  logic [3:0]       d_mask_reg, d_mask_next;
  logic [31:0]      d_hold_reg;
  logic [31:0]      d_ram_q;
  logic             d_rd_en;
  logic             d_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state_reg <= IDLE;
      d_cnt_reg   <= '0;
      d_idx_reg   <= '0;
      d_oob_reg   <= 1'b0;
      d_wr_reg    <= 1'b0;
      d_wdata_reg <= '0;
      d_mask_reg  <= '0;
    end else begin
      d_state_reg <= d_state_next;
      d_cnt_reg   <= d_cnt_next;
      d_idx_reg   <= d_idx_next;
      d_oob_reg   <= d_oob_next;
      d_wr_reg    <= d_wr_next;
      d_wdata_reg <= d_wdata_next;
      d_mask_reg  <= d_mask_next;
    end
  end

  always_comb begin
    d_state_next = d_state_reg;
    d_cnt_next   = d_cnt_reg;
    d_idx_next   = d_idx_reg;
    d_oob_next   = d_oob_reg;
    d_wr_next    = d_wr_reg;
    d_wdata_next = d_wdata_reg;
    d_mask_next  = d_mask_reg;
    case (d_state_reg)
      IDLE: begin
        // A simultaneous read request is dropped in favour of the write.
        if (data_rd_req || data_wr_req) begin
          d_idx_next   = data_addr[AW+1:2];
          d_oob_next   = d_req_oob;
          d_wr_next    = data_wr_req;
          d_wdata_next = data_wr_data;
          d_mask_next  = data_wr_mask;
          d_cnt_next   = DWAIT_C;
          d_state_next = (DWAIT_C == '0) ? GRANT : WAIT;
        end
      end
      WAIT: begin
        d_cnt_next = d_cnt_reg - CNT_W'(1);
        if (d_cnt_reg <= CNT_W'(1)) d_state_next = GRANT;
      end
      GRANT: begin
        d_cnt_next   = '0;
        d_state_next = IDLE;
      end
      default: d_state_next = IDLE;
    endcase
  end

  // Reads are issued on the edge into GRANT; writes commit on the edge leaving it.
  assign d_rd_en      = (d_state_next == GRANT) && !d_wr_next;
  assign d_we         = (d_state_reg == GRANT) && d_wr_reg && !d_oob_reg;
  assign data_gnt     = (d_state_reg == GRANT);
  assign data_rd_data = data_gnt ? ((d_wr_reg || d_oob_reg) ? 32'd0 : d_ram_q) : d_hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_hold_reg <= '0;
    else if (data_gnt) d_hold_reg <= data_rd_data;
  end

`ifdef KRONOS_MEM_BOUNDS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_err <= 1'b0;
    else if (((i_state_next == GRANT) && i_oob_next) ||
             ((d_state_next == GRANT) && d_oob_next)) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

  kronos_dpram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .a_re   (i_state_next == GRANT),
    .a_addr (i_idx_next),
    .a_q    (i_ram_q),
    .b_re   (d_rd_en),
    .b_we   (d_we),
    .b_be   (d_mask_reg),
    .b_addr (d_idx_next),
    .b_wdata(d_wdata_reg),
    .b_q    (d_ram_q)
  );

endmodule

// File: doc/kronos_mem_responder.md
KRONOS_MEM_RESPONDER -- requirements
Module: kronos_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter IWAIT, default 0, extra wait cycles on the instruction port (0-15).
REQ-003 SHALL have parameter DWAIT, default 1, extra wait cycles on the data port (0-15).
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: instr_addr  in  32  byte address; instr_req  in  1  fetch request; instr_data  out  32  read word; instr_gnt  out  1  request served.
REQ-006 SHALL have ports: data_addr  in  32  byte address; data_wr_data  in  32  write word; data_wr_mask  in  4  byte enables; data_rd_req  in  1  read request; data_wr_req  in  1  write request.
REQ-007 SHALL have ports: data_rd_data  out  32  read word; data_gnt  out  1  request served; bus_err  out  1  sticky out-of-range flag.

Function
REQ-008 SHALL run one independent FSM per port with states IDLE, WAIT, GRANT.
REQ-009 In IDLE, a sampled request SHALL latch the address (plus write data and mask on the data port), load the wait counter with IWAIT or DWAIT, and move to WAIT.
REQ-010 In WAIT, the counter SHALL decrement each cycle; at zero the FSM SHALL move to GRANT.
REQ-011 In GRANT, gnt SHALL be high for exactly one cycle with read data valid in the same cycle; the FSM then SHALL return to IDLE.
REQ-012 Latency: request first seen at cycle t, gnt at cycle t+1+WAIT. Back-to-back requests SHALL incur one IDLE cycle between gnts.
REQ-013 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] SHALL be ignored.
REQ-014 A write SHALL update only the bytes whose data_wr_mask bit is set, committed in the GRANT cycle; data_rd_data on a write grant SHALL be 0.
REQ-015 If data_rd_req and data_wr_req are both high in IDLE, the write SHALL win and the read SHALL be dropped.
REQ-016 A same-word instruction read and data write granted in the same cycle SHALL return the old word (read-first).
REQ-017 A request deasserted before gnt SHALL still complete internally; gnt SHALL still pulse.
REQ-018 instr_data and data_rd_data SHALL hold their last value outside GRANT cycles.

Reset
REQ-019 While rst is high, both FSMs SHALL be in IDLE, counters 0, instr_gnt=0, data_gnt=0, instr_data=0, data_rd_data=0, bus_err=0.
REQ-020 Reset mid-transaction SHALL abort it with no gnt and no write commit; memory contents SHALL be retained, not cleared.

Configuration
REQ-021 With macro KRONOS_MEM_BOUNDS_EN defined, an access with addr >= 4*DEPTH_WORDS SHALL be granted with the normal timing, return read data 0, suppress the write, and set bus_err until reset.
REQ-022 Without KRONOS_MEM_BOUNDS_EN, out-of-range addresses SHALL wrap modulo DEPTH_WORDS, and bus_err SHALL be tied to 0.

Structure
REQ-023 The FSM state enum (mem_state_e: IDLE, WAIT, GRANT) SHALL live in kronos_types.
REQ-024 The storage array SHALL be a sub-module, kronos_dpram, with one read port and one byte-masked read/write port, both synchronous.

Verification
REQ-025 Scenario: reset, then write 0xDEADBEEF to 0x10 with mask 4'hF, then read 0x10 -> data_gnt at t+2 each time (DWAIT=1); read returns 0xDEADBEEF.
REQ-026 Scenario: with 0x10 holding 0xDEADBEEF, write 0x000000AA with mask 4'h1, then read -> read returns 0xDEADBEAA.
REQ-027 Scenario: instr_req to 0x10 held high for 3 fetches (IWAIT=0) -> instr_gnt pulses at t+1, t+3, t+5, each with correct data.
REQ-028 Scenario: same-cycle grant of an instruction read and a data write to 0x20 (old 0x11111111, new 0x22222222) -> instr_data=0x11111111; a following fetch returns 0x22222222.
REQ-029 Scenario: rst asserted during WAIT of a write to 0x30 -> no data_gnt; 0x30 unchanged on a later read.
REQ-030 Scenario: with KRONOS_MEM_BOUNDS_EN, DEPTH_WORDS=1024, read 0x1000 -> gnt with data 0 and bus_err=1 sticky; without the macro -> returns the word at 0x0.
